// File: rtl/video_timing_gen_pkg.sv
// Raster timing presets and helpers shared by the video timing generator.
// Each preset lists act/fp/sync/bp for H and V; totals are their sums.
package video_timing_pkg;

    localparam int TW = 16;
    localparam int MAX_H_TOTAL = 800;
    localparam int MAX_V_TOTAL = 312;

    typedef enum logic [1:0] {
        MODE_240P = 2'd0,
        MODE_224P = 2'd1,
        MODE_480I = 2'd2,
        MODE_288P = 2'd3
    } mode_e;

    typedef struct packed {
        logic [TW-1:0] act;
        logic [TW-1:0] fp;
        logic [TW-1:0] sync;
        logic [TW-1:0] bp;
    } timing_t;

    typedef struct packed {
        timing_t h;
        timing_t v;
    } preset_t;

    // V timing of 480i is field 0; field 1 carries one extra back-porch line.
    localparam preset_t PRESETS [4] = '{
        '{h: '{act: 16'd320, fp: 16'd16, sync: 16'd32, bp: 16'd32},
          v: '{act: 16'd240, fp: 16'd3,  sync: 16'd3,  bp: 16'd16}},
        '{h: '{act: 16'd256, fp: 16'd16, sync: 16'd24, bp: 16'd24},
          v: '{act: 16'd224, fp: 16'd11, sync: 16'd3,  bp: 16'd24}},
        '{h: '{act: 16'd640, fp: 16'd16, sync: 16'd64, bp: 16'd80},
          v: '{act: 16'd240, fp: 16'd3,  sync: 16'd3,  bp: 16'd16}},
        '{h: '{act: 16'd320, fp: 16'd16, sync: 16'd32, bp: 16'd32},
          v: '{act: 16'd288, fp: 16'd3,  sync: 16'd3,  bp: 16'd18}}
    };

    function automatic logic [TW-1:0] timing_total(timing_t t);
        return t.act + t.fp + t.sync + t.bp;
    endfunction

    function automatic logic [TW-1:0] h_total(mode_e m);
        return timing_total(PRESETS[m].h);
    endfunction

    function automatic logic [TW-1:0] v_total(mode_e m, logic field);
        return timing_total(PRESETS[m].v) + ((m == MODE_480I && field) ? TW'(1) : TW'(0));
    endfunction

    // Returns {blank, sync_active} for a position along one axis.
    function automatic logic [1:0] region(timing_t t, logic [TW-1:0] pos);
        logic blank;
        logic sync_act;
        blank    = (pos >= t.act);
        sync_act = (pos >= t.act + t.fp) && (pos < t.act + t.fp + t.sync);
        return {blank, sync_act};
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Mode select in, raster timing out; the generator drives the master side.
interface video_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
);
    logic [1:0]    mode;
    logic          ce_pix;
    logic          h_sync;
    logic          v_sync;
    logic          h_blank;
    logic          v_blank;
    logic          de;
    logic          f1;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          new_frame;
    logic [1:0]    cur_mode;

    modport master (
        input  mode,
        output ce_pix, h_sync, v_sync, h_blank, v_blank, de, f1, x, y, new_frame, cur_mode
    );

    modport slave (
        output mode,
        input  ce_pix, h_sync, v_sync, h_blank, v_blank, de, f1, x, y, new_frame, cur_mode
    );
endinterface

// File: rtl/video_timing_gen_ce_divider.sv
// Pixel-enable divider: tick is the combinational strobe one clk ahead of
// the registered ce_pix, so counters stepping on tick change with ce_pix.
module ce_divider #(
    parameter int CE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic ce_pix
);
    localparam int DW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          ce_pix_q, ce_pix_d;

    always_comb begin
        tick     = (div_q == DIV_LAST);
        div_d    = tick ? '0 : div_q + DW'(1);
        ce_pix_d = tick;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            ce_pix_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            ce_pix_q <= ce_pix_d;
        end
    end

    assign ce_pix = ce_pix_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, sync/blank/DE decode and interlace
// field flag; mode changes are latched only at the start of a frame.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CE_DIV   = 4,
    parameter int HW       = 10,
    parameter int VW       = 10,
    parameter int SYNC_POL = 1
) (
    input  logic clk,
    input  logic reset,
    video_timing_gen_if.master vid
);
    localparam logic SYNC_INACTIVE = (SYNC_POL == 0);

    if (CE_DIV < 2 || CE_DIV > 16) begin : g_bad_ce_div
        $error("CE_DIV must be within 2..16");
    end
    if (MAX_H_TOTAL > (1 << HW) - 1) begin : g_bad_hw
        $error("HW too narrow for the largest horizontal total");
    end
    if (MAX_V_TOTAL > (1 << VW) - 1) begin : g_bad_vw
        $error("VW too narrow for the largest vertical total");
    end

    logic tick;
    logic ce_pix;

    ce_divider #(.CE_DIV(CE_DIV)) u_ce_divider (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .ce_pix (ce_pix)
    );

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          f1_q, f1_d;
    mode_e         cur_mode_q, cur_mode_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          h_blank_q, h_blank_d;
    logic          v_blank_q, v_blank_d;
    logic          de_q, de_d;
    logic          new_frame_q, new_frame_d;
    logic          h_last, v_last;
    logic          hs_act, vs_act;

    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        f1_d        = f1_q;
        cur_mode_d  = cur_mode_q;
        h_sync_d    = h_sync_q;
        v_sync_d    = v_sync_q;
        h_blank_d   = h_blank_q;
        v_blank_d   = v_blank_q;
        de_d        = de_q;
        new_frame_d = 1'b0;
        hs_act      = 1'b0;
        vs_act      = 1'b0;
        h_last      = (TW'(h_q) == h_total(cur_mode_q) - TW'(1));
        v_last      = (TW'(v_q) == v_total(cur_mode_q, f1_q) - TW'(1));

        if (tick) begin
            if (h_last) begin
                h_d = '0;
                if (v_last) begin
                    v_d = '0;
                    if (cur_mode_q == MODE_480I) f1_d = ~f1_q;
                    // A new mode only lands where the next field is field 0.
                    if (!f1_d) cur_mode_d = mode_e'(vid.mode);
                end else begin
                    v_d = v_q + VW'(1);
                end
            end else begin
                h_d = h_q + HW'(1);
            end

            {h_blank_d, hs_act} = region(PRESETS[cur_mode_d].h, TW'(h_d));
            {v_blank_d, vs_act} = region(PRESETS[cur_mode_d].v, TW'(v_d));
            de_d        = ~(h_blank_d | v_blank_d);
            h_sync_d    = hs_act ^ SYNC_INACTIVE;
            v_sync_d    = vs_act ^ SYNC_INACTIVE;
            new_frame_d = (h_d == '0) && (v_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q         <= '0;
            v_q         <= '0;
            f1_q        <= 1'b0;
            cur_mode_q  <= mode_e'(vid.mode);
            h_sync_q    <= SYNC_INACTIVE;
            v_sync_q    <= SYNC_INACTIVE;
            h_blank_q   <= 1'b0;
            v_blank_q   <= 1'b0;
            de_q        <= 1'b0;
            new_frame_q <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            f1_q        <= f1_d;
            cur_mode_q  <= cur_mode_d;
            h_sync_q    <= h_sync_d;
            v_sync_q    <= v_sync_d;
            h_blank_q   <= h_blank_d;
            v_blank_q   <= v_blank_d;
            de_q        <= de_d;
            new_frame_q <= new_frame_d;
        end
    end

    assign vid.ce_pix    = ce_pix;
    assign vid.h_sync    = h_sync_q;
    assign vid.v_sync    = v_sync_q;
    assign vid.h_blank   = h_blank_q;
    assign vid.v_blank   = v_blank_q;
    assign vid.de        = de_q;
    assign vid.f1        = f1_q;
    assign vid.x         = h_q;
    assign vid.y         = v_q;
    assign vid.new_frame = new_frame_q;
    assign vid.cur_mode  = cur_mode_q;

endmodule
